// File: rtl/biquad_pkg.sv
// Shared definitions for the biquad sequencer.
//   - Coefficient bank addresses as seen on cfg_addr.
//   - Timer width for the strobe-spacing counter.
//   - Sequencer state encoding (warm-up vs. running).
//   - warm_width(): width of the saturating warm-up counter.
package biquad_pkg;

  localparam int TIMER_W  = 8;
  localparam int NUM_COEF = 5;

  localparam logic [2:0] ADDR_B10 = 3'd0;
  localparam logic [2:0] ADDR_B11 = 3'd1;
  localparam logic [2:0] ADDR_B12 = 3'd2;
  localparam logic [2:0] ADDR_A11 = 3'd3;
  localparam logic [2:0] ADDR_A12 = 3'd4;

  typedef enum logic {
    WARM = 1'b0,  // filter pipeline still filling, results are discarded
    RUN  = 1'b1   // results are captured onto the output stream
  } seq_state_t;

  // A zero-latency build still needs a one-bit counter to keep widths legal.
  function automatic int warm_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/biquad_sequencer_sync_fifo.sv
// sync_fifo: small synchronous FIFO feeding the filter strobe.
//   clk, reset : clock, synchronous active-high reset
//   push, wdata: write request and data (ignored when full)
//   pop        : remove head (ignored when empty)
//   head       : current head entry (valid when !empty)
//   full, empty: occupancy flags decoded from the count register
//   ready      : registered not-full flag, 0 while in reset
module sync_fifo #(
  parameter int DATAWIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] head,
  output logic                 full,
  output logic                 empty,
  output logic                 ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATAWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [CNT_W-1:0]     count_next;
  logic                 ready_reg;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign ready   = ready_reg;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      ready_reg <= (count_next != CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/biquad_sequencer.sv
// biquad_sequencer: drives one biquad section and collects its output.
//   clk, reset          : clock, synchronous active-high reset
//   s_data/s_valid/s_ready : input sample stream (buffered in a FIFO)
//   m_data/m_valid/m_ready : filtered sample stream
//   flush               : strobe zero samples while the FIFO is empty
//   cfg_we/cfg_addr/cfg_wdata : shadow coefficient writes
//   cfg_commit, commit_pending : shadow-to-active copy request / status
//   bq_x, bq_valid, bq_enable, bq_y : filter section interface
//   a11, a12, b10, b11, b12 : active coefficients
// The filter is strobed once per CYCLES clocks at most; its output is
// sampled one cycle after the strobe, and the first LATENCY results after
// reset are thrown away while the pipeline fills.
module biquad_sequencer
  import biquad_pkg::*;
#(
  parameter int DATAWIDTH  = 16,
  parameter int COEFWIDTH  = 16,
  parameter int CYCLES     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  input  logic                 flush,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [COEFWIDTH-1:0] cfg_wdata,
  input  logic                 cfg_commit,
  output logic                 commit_pending,
  output logic [DATAWIDTH-1:0] bq_x,
  output logic                 bq_valid,
  output logic                 bq_enable,
  input  logic [DATAWIDTH-1:0] bq_y,
  output logic [COEFWIDTH-1:0] a11,
  output logic [COEFWIDTH-1:0] a12,
  output logic [COEFWIDTH-1:0] b10,
  output logic [COEFWIDTH-1:0] b11,
  output logic [COEFWIDTH-1:0] b12
);

  localparam int WARM_W = warm_width(LATENCY);

  // ---------------------------------------------------------------- FIFO
  logic [DATAWIDTH-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_ready;
  logic                 push;
  logic                 pop;

  // fifo_ready is the registered copy of !full; full is the same condition
  // decoded from the count and keeps the push guard self-contained.
  assign push    = s_valid && fifo_ready && !fifo_full;
  assign s_ready = fifo_ready;

  sync_fifo #(
    .DATAWIDTH  (DATAWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ready (fifo_ready)
  );

  // ------------------------------------------------------ strobe timing
  logic [TIMER_W-1:0]   timer_reg;
  logic                 slot;
  logic                 out_free;
  logic                 strobe;
  logic                 bq_valid_reg;
  logic [DATAWIDTH-1:0] bq_x_reg;
  logic                 bq_enable_reg;
  logic                 cap_reg;
  logic                 m_valid_reg;
  logic [DATAWIDTH-1:0] m_data_reg;

  assign slot = (timer_reg == TIMER_W'(CYCLES - 1));

  // The output register must be empty (or emptying now) and no earlier
  // strobe may still be on its way to it. The in-flight terms only bite
  // for CYCLES below 3, where a result could otherwise be overwritten.
  assign out_free = (!m_valid_reg || m_ready) && !bq_valid_reg && !cap_reg;
  assign strobe   = slot && (!fifo_empty || flush) && out_free;
  assign pop      = strobe && !fifo_empty;

  // ---------------------------------------------------- warm-up FSM
  seq_state_t           state_reg;
  seq_state_t           state_next;
  logic [WARM_W-1:0]    warm_cnt_reg;
  logic                 capture;
  logic                 discard;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= (LATENCY == 0) ? RUN : WARM;
      warm_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (discard) warm_cnt_reg <= warm_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WARM: if (cap_reg && (warm_cnt_reg == WARM_W'(LATENCY - 1))) state_next = RUN;
      RUN:  state_next = RUN;
      default: state_next = WARM;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    discard = 1'b0;
    case (state_reg)
      WARM:    discard = cap_reg;
      RUN:     capture = cap_reg;
      default: discard = 1'b0;
    endcase
  end

  // ----------------------------------------------------- datapath regs
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg     <= '0;
      bq_valid_reg  <= 1'b0;
      bq_x_reg      <= '0;
      bq_enable_reg <= 1'b0;
      cap_reg       <= 1'b0;
      m_valid_reg   <= 1'b0;
      m_data_reg    <= '0;
    end else begin
      timer_reg     <= slot ? '0 : timer_reg + 1'b1;
      bq_enable_reg <= 1'b1;
      bq_valid_reg  <= strobe;
      cap_reg       <= bq_valid_reg;
      if (strobe) bq_x_reg <= fifo_empty ? '0 : fifo_head;
      if (capture) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= bq_y;
      end else if (m_valid_reg && m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign bq_valid  = bq_valid_reg;
  assign bq_x      = bq_x_reg;
  assign bq_enable = bq_enable_reg;
  assign m_valid   = m_valid_reg;
  assign m_data    = m_data_reg;

  // ------------------------------------------------- coefficient bank
  logic [COEFWIDTH-1:0] shadow_reg [NUM_COEF];
  logic [COEFWIDTH-1:0] active_reg [NUM_COEF];
  logic [NUM_COEF-1:0]  wr_sel;
  logic                 commit_pending_reg;
  logic                 commit_copy;

  // Copying only at timer 0 keeps the active bank still around every strobe.
  assign commit_copy = (timer_reg == '0) && commit_pending_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COEF; gi = gi + 1) begin : g_wr_sel
      assign wr_sel[gi] = cfg_we && (cfg_addr == 3'(gi));
    end
  endgenerate

  // Non-blocking update: a copy in the same cycle as a write takes the
  // old shadow value, the write lands in shadow only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
      commit_pending_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_COEF; i++) begin
        if (wr_sel[i])   shadow_reg[i] <= cfg_wdata;
        if (commit_copy) active_reg[i] <= shadow_reg[i];
      end
      if (cfg_commit)       commit_pending_reg <= 1'b1;
      else if (commit_copy) commit_pending_reg <= 1'b0;
    end
  end

  assign commit_pending = commit_pending_reg;
  assign b10 = active_reg[ADDR_B10];
  assign b11 = active_reg[ADDR_B11];
  assign b12 = active_reg[ADDR_B12];
  assign a11 = active_reg[ADDR_A11];
  assign a12 = active_reg[ADDR_A12];

endmodule

// File: tb/tb_biquad_sequencer.sv
// Self-checking bench for biquad_sequencer (CYCLES=4, LATENCY=2, depth 4).
// A transaction-level model (sample queue, strobe counter, slot index from
// elapsed clocks) predicts every output each cycle; directed phases follow
// the feature list, then a randomized phase with occasional resets.
module tb_biquad_sequencer;

  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int CYC   = 4;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          flush = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_wdata = '0;
  logic          cfg_commit = 1'b0;
  logic          commit_pending;
  logic [DW-1:0] bq_x;
  logic          bq_valid;
  logic          bq_enable;
  logic [DW-1:0] bq_y = '0;
  logic [CW-1:0] a11, a12, b10, b11, b12;

  always #5 clk = ~clk;

  biquad_sequencer #(
    .DATAWIDTH (DW), .COEFWIDTH (CW), .CYCLES (CYC),
    .FIFO_DEPTH (DEPTH), .LATENCY (LAT)
  ) dut (
    .clk (clk), .reset (reset),
    .s_data (s_data), .s_valid (s_valid), .s_ready (s_ready),
    .m_data (m_data), .m_valid (m_valid), .m_ready (m_ready),
    .flush (flush),
    .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_wdata (cfg_wdata),
    .cfg_commit (cfg_commit), .commit_pending (commit_pending),
    .bq_x (bq_x), .bq_valid (bq_valid), .bq_enable (bq_enable), .bq_y (bq_y),
    .a11 (a11), .a12 (a12), .b10 (b10), .b11 (b11), .b12 (b12)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------- reference model
  logic [DW-1:0] mq[$];          // queued samples
  int            tick = 0;       // clocks since reset released
  int            nstrobe = 0;    // strobes since reset
  bit            mv = 0;
  logic [DW-1:0] md = '0;
  bit            bv = 0;
  logic [DW-1:0] bx = '0;
  bit            sr = 0;
  bit            en = 0;
  bit            pend = 0;
  logic [CW-1:0] sh [5];
  logic [CW-1:0] act [5];
  int            cap_cnt = 0;    // clocks until the pending result lands
  logic [DW-1:0] cap_v = '0;
  bit            cap_d = 0;
  logic [DW-1:0] yval = '0;      // value presented on bq_y for the last strobe

  // DUT-side observations for directed checks
  int            bq_cnt = 0;
  int            rx_cnt = 0;

  task automatic model_edge();
    int  timer;
    bit  strobe;
    bit  new_mv;
    if (reset) begin
      mq.delete();
      tick = 0; nstrobe = 0; mv = 0; md = '0; bv = 0; bx = '0;
      sr = 0; en = 0; pend = 0; cap_cnt = 0; yval = '0;
      for (int i = 0; i < 5; i++) begin sh[i] = '0; act[i] = '0; end
      return;
    end
    timer  = tick % CYC;
    strobe = (timer == CYC - 1) && (mq.size() > 0 || flush) && (!mv || m_ready);
    new_mv = mv;
    if (mv && m_ready) begin
      new_mv = 0;
      $display("txn out m_data=0x%04h", md);
    end
    if (cap_cnt > 0) begin
      cap_cnt--;
      if (cap_cnt == 0 && !cap_d) begin new_mv = 1; md = cap_v; end
    end
    bv = strobe;
    if (strobe) begin
      nstrobe++;
      bx = (mq.size() > 0) ? mq.pop_front() : '0;
      cap_cnt = 2;
      cap_v = DW'(nstrobe);
      cap_d = (nstrobe <= LAT);
      yval = cap_v;
    end
    if (s_valid && sr) mq.push_back(s_data);
    sr = (mq.size() < DEPTH);
    en = 1;
    if (timer == 0 && pend) begin
      for (int i = 0; i < 5; i++) act[i] = sh[i];
      pend = 0;
    end
    if (cfg_we && cfg_addr < 5) sh[cfg_addr] = cfg_wdata;
    if (cfg_commit) pend = 1;
    mv = new_mv;
    tick++;
  endtask

  task automatic compare_all();
    check_val("s_ready", s_ready, sr);
    check_val("m_valid", m_valid, mv);
    check_val("m_data", m_data, md);
    check_val("bq_valid", bq_valid, bv);
    check_val("bq_x", bq_x, bx);
    check_val("bq_enable", bq_enable, en);
    check_val("commit_pending", commit_pending, pend);
    check_val("b10", b10, act[0]);
    check_val("b11", b11, act[1]);
    check_val("b12", b12, act[2]);
    check_val("a11", a11, act[3]);
    check_val("a12", a12, act[4]);
  endtask

  // One clock: model consumes the current inputs, DUT takes the edge,
  // outputs are compared mid-cycle.
  task automatic cycle();
    if (m_valid && m_ready) rx_cnt++;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    bq_y = yval;
    if (bq_valid) bq_cnt++;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_sample(input logic [DW-1:0] d);
    bit acc;
    int guard;
    s_data  = d;
    s_valid = 1'b1;
    guard   = 0;
    do begin
      acc = sr;
      cycle();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) check_val("push_timeout", 32'(guard), 32'(0));
    s_valid = 1'b0;
  endtask

  bit            full_seen;
  logic [DW-1:0] md_hold;

  initial begin
    for (int i = 0; i < 5; i++) begin sh[i] = '0; act[i] = '0; end
    @(negedge clk);
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    cycle();
    check_val("s_ready_after_reset", s_ready, 1'b1);
    check_val("bq_enable_after_reset", bq_enable, 1'b1);

    // Back-to-back pushes starting on a slot cycle so the FIFO fills.
    m_ready = 1'b1;
    while (tick % CYC != CYC - 1) cycle();
    full_seen = 0;
    s_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bit acc;
      int guard = 0;
      s_data = DW'(i * 16'h1000);
      do begin
        acc = sr;
        cycle();
        if (!s_ready) full_seen = 1;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) check_val("push_timeout", 32'(guard), 32'(0));
    end
    s_valid = 1'b0;
    check_val("fifo_full_seen", full_seen, 1'b1);
    rx_cnt = 0;
    run(28);
    check_val("rx_after_warmup", rx_cnt, 3);

    // Backpressure: result held, no strobes while it is unconsumed.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_sample(DW'(16'hA000 + i));
    run(12);
    check_val("bp_m_valid", m_valid, 1'b1);
    md_hold = m_data;
    bq_cnt = 0;
    run(16);
    check_val("bp_no_strobe", bq_cnt, 0);
    check_val("bp_m_data_stable", m_data, md_hold);
    m_ready = 1'b1;
    bq_cnt = 0;
    run(16);
    check_val("bp_resume_strobes", bq_cnt, 2);

    // Shadow write without commit, then commit.
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'h4000;
    cycle();
    cfg_we = 1'b0;
    run(8);
    check_val("b10_uncommitted", b10, 16'h0000);
    while (tick % CYC == 0) cycle();
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    check_val("commit_pending_set", commit_pending, 1'b1);
    for (int i = 0; i < 8 && b10 != 16'h4000; i++) cycle();
    check_val("b10_committed", b10, 16'h4000);
    check_val("commit_pending_clear", commit_pending, 1'b0);

    // Flush with empty FIFO.
    flush = 1'b1;
    bq_cnt = 0;
    run(12);
    check_val("flush_strobes", bq_cnt, 3);
    flush = 1'b0;
    bq_cnt = 0;
    run(8);
    check_val("no_flush_strobes", bq_cnt, 0);

    // Reset mid-operation with queued samples and a held result.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_sample(DW'(16'hC000 + i));
    run(12);
    check_val("pre_reset_m_valid", m_valid, 1'b1);
    reset = 1'b1;
    cycle();
    check_val("reset_m_valid", m_valid, 1'b0);
    check_val("reset_s_ready", s_ready, 1'b0);
    reset = 1'b0;
    cycle();
    check_val("post_reset_s_ready", s_ready, 1'b1);
    m_ready = 1'b1;
    rx_cnt = 0;
    for (int i = 0; i < 3; i++) push_sample(DW'(16'hD000 + i));
    run(20);
    check_val("post_reset_rx", rx_cnt, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s_valid    = ($urandom % 2) == 0;
      s_data     = DW'($urandom);
      m_ready    = ($urandom % 4) != 0;
      flush      = ($urandom % 16) == 0;
      cfg_we     = ($urandom % 8) == 0;
      cfg_addr   = 3'($urandom);
      cfg_wdata  = CW'($urandom);
      cfg_commit = (tick % CYC != 0) && (($urandom % 16) == 0);
      reset      = ($urandom % 500) == 0;
      cycle();
    end
    reset = 1'b0; s_valid = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/biquad_sequencer.md
Name: biquad_sequencer

Overview:
- Upstream driver and downstream collector for one biquad filter section.
- Accepts samples on a ready/valid stream and buffers them in a small FIFO.
- Issues the section's single-cycle valid strobe at a fixed spacing of CYCLES clocks, which the multicycle multipliers require.
- Captures the section output after pipeline warm-up onto a ready/valid output stream, and owns the double-buffered coefficient bank that feeds the section.

Parameters:
- DATAWIDTH, 16, sample width at both streams and at the filter.
- COEFWIDTH, 16, coefficient width.
- CYCLES, 4, clocks between filter strobes; legal range 1..255.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2, at least 2.
- LATENCY, 2, number of initial strobe results discarded after reset.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- s_data, in, DATAWIDTH, input sample.
- s_valid, in, 1, input sample valid.
- s_ready, out, 1, FIFO can accept a sample.
- m_data, out, DATAWIDTH, filtered sample.
- m_valid, out, 1, m_data holds an unconsumed result.
- m_ready, in, 1, downstream accepts m_data.
- flush, in, 1, level signal; strobe zero samples when the FIFO is empty.
- cfg_we, in, 1, shadow coefficient write.
- cfg_addr, in, 3, 0=b10, 1=b11, 2=b12, 3=a11, 4=a12; 5-7 are ignored.
- cfg_wdata, in, COEFWIDTH, shadow write data.
- cfg_commit, in, 1, request copy of shadow to active.
- commit_pending, out, 1, a commit is waiting to take effect.
- bq_x, out, DATAWIDTH, filter data input.
- bq_valid, out, 1, filter strobe.
- bq_enable, out, 1, filter multiplier enable.
- bq_y, in, DATAWIDTH, filter output.
- a11, a12, b10, b11, b12, out, COEFWIDTH each, active coefficients.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - All outputs are 0 while reset is high, including s_ready, bq_enable and the coefficients.
  - The FIFO is emptied, the timer is 0, the warm-up count is 0, and the shadow bank and commit_pending are cleared.
  - The first cycle after reset: s_ready=1 and bq_enable=1.
  - Asserting reset mid-operation discards all FIFO contents and any in-flight result.
- Timer: counts 0..CYCLES-1 and wraps. It runs continuously out of reset.
- Strobe slot: the cycle in which the timer equals CYCLES-1.
- A strobe is issued in a slot only if both hold:
  - the FIFO is non-empty, or the FIFO is empty and flush=1;
  - the output register is free, meaning m_valid=0 or m_valid=1 with m_ready=1 in the same cycle.
- Strobe action: bq_valid=1 for exactly one cycle, and bq_x is registered at the same edge.
  - bq_x is the FIFO head, which is popped.
  - On a flush strobe, bq_x is 0 and nothing is popped.
- A slot without a strobe is skipped, and the timer keeps running.
- bq_valid is never asserted in consecutive cycles when CYCLES>1.
- Capture:
  - The cycle after a strobe, bq_y is sampled.
  - Results from the first LATENCY strobes after reset are discarded; the warm-up counter saturates at LATENCY.
  - Each later strobe loads m_data and sets m_valid=1.
- Output hold: m_data and m_valid stay stable until the handshake m_valid&m_ready completes.
  - The strobe gating above guarantees a result is never overwritten.
- FIFO:
  - s_ready is the registered not-full flag; there is no same-cycle pop bypass.
  - A push occurs on s_valid&s_ready.
  - A simultaneous push and pop when not full updates both, and the count is unchanged.
  - Data order is preserved across pointer wrap.
- Coefficients:
  - cfg_we writes the shadow register at cfg_addr in one cycle.
  - cfg_commit sets commit_pending.
  - When the timer is 0 and commit_pending=1, the shadow bank is copied to the active outputs and commit_pending clears.
  - Active coefficients therefore never change in a strobe cycle or the cycle after one (CYCLES≥3).
  - cfg_we and the commit copy in the same cycle: the copy uses the pre-write shadow, and the write lands in shadow only.
  - cfg_commit while a commit is already pending keeps a single pending commit.
- Arithmetic: no arithmetic beyond counters. Widths:
  - timer is 8 bits;
  - warm-up count is clog2(LATENCY+1) bits;
  - FIFO count is clog2(FIFO_DEPTH)+1 bits.
- States: WARM (warm-up count < LATENCY, results discarded) and RUN (results captured). The only way back to WARM is reset.

Decomposition:
- Shared package biquad_pkg holds:
  - coefficient address constants (ADDR_B10=0 ... ADDR_A12=4);
  - the timer width;
  - the sequencer state encoding WARM/RUN.
- One sub-module is natural: sync_fifo (parameters DATAWIDTH, FIFO_DEPTH; ports push, pop, full, empty, head).

Test Plan (CYCLES=4, LATENCY=2, FIFO_DEPTH=4):
- Push 0x1000, 0x2000, 0x3000, 0x4000, 0x5000 back-to-back with m_ready=1 -> s_ready drops after the 4th accept, and bq_valid pulses exactly 4 clocks apart with bq_x 0x1000, 0x2000, ... in order.
- With bq_y driven as strobe index 1, 2, 3, 4 -> the first two are discarded, and m_data=3 then 4, each with a single m_valid handshake.
- Hold m_ready=0 while m_valid=1 and the FIFO holds 2 samples -> no bq_valid and m_data stable; raise m_ready -> the strobe resumes at the next slot.
- cfg_we b10=0x4000 without commit -> b10 stays 0; pulse cfg_commit -> b10=0x4000 at the next timer=0 cycle, never in a bq_valid cycle, and commit_pending then clears.
- FIFO empty, flush=1 for 12 clocks -> 3 strobes with bq_x=0 and no pops; flush=0 -> no strobes.
- Assert reset with 3 samples queued and m_valid=1 -> the next cycle all outputs are 0; the first cycle after reset s_ready=1, and two new strobes are discarded again.
